// File: rtl/vga_timing_param_if.sv
// Timing-generator bundle: pixel enable and mode request in, counts, syncs, blanks and pulses out.
// The generator takes the master modport; the pixel pipeline consuming the timing takes slave.
interface vga_timing_param_if #(
  parameter int unsigned HW = 11,
  parameter int unsigned VW = 10,
  parameter int unsigned FW = 16
);
  logic          ce;
  logic          mode_sel;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblnk;
  logic          vblnk;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic [FW-1:0] frame_cnt;
  logic          mode_act;

  modport master (
    input  ce,
    input  mode_sel,
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output hblnk,
    output vblnk,
    output de,
    output line_start,
    output frame_start,
    output frame_cnt,
    output mode_act
  );

  modport slave (
    output ce,
    output mode_sel,
    input  hcount,
    input  vcount,
    input  hsync,
    input  vsync,
    input  hblnk,
    input  vblnk,
    input  de,
    input  line_start,
    input  frame_start,
    input  frame_cnt,
    input  mode_act
  );
endinterface

// File: rtl/vga_timing_param.sv
// Two-mode VGA raster timing generator with fully registered, zero-latency decoded outputs.
// Mode switches only at the frame wrap so a frame never mixes two timing sets.
module vga_timing_param #(
  parameter int unsigned M0_H_TOTAL  = 1344,
  parameter int unsigned M0_H_ACTIVE = 1024,
  parameter int unsigned M0_HS_START = 1048,
  parameter int unsigned M0_HS_LEN   = 136,
  parameter int unsigned M0_V_TOTAL  = 806,
  parameter int unsigned M0_V_ACTIVE = 768,
  parameter int unsigned M0_VS_START = 771,
  parameter int unsigned M0_VS_LEN   = 6,
  parameter int unsigned M1_H_TOTAL  = 1056,
  parameter int unsigned M1_H_ACTIVE = 800,
  parameter int unsigned M1_HS_START = 840,
  parameter int unsigned M1_HS_LEN   = 128,
  parameter int unsigned M1_V_TOTAL  = 628,
  parameter int unsigned M1_V_ACTIVE = 600,
  parameter int unsigned M1_VS_START = 601,
  parameter int unsigned M1_VS_LEN   = 4,
  parameter bit          HSYNC_POL   = 1'b1,
  parameter bit          VSYNC_POL   = 1'b1,
  parameter int unsigned HW          = 11,
  parameter int unsigned VW          = 10,
  parameter int unsigned FW          = 16
) (
  input logic                   clk,
  input logic                   rst,
  vga_timing_param_if.master    tif
);

  localparam logic [HW-1:0] M0HLast    = HW'(M0_H_TOTAL - 1);
  localparam logic [HW-1:0] M0HAct     = HW'(M0_H_ACTIVE);
  localparam logic [HW-1:0] M0HsFirst  = HW'(M0_HS_START);
  localparam logic [HW-1:0] M0HsLast   = HW'(M0_HS_START + M0_HS_LEN - 1);
  localparam logic [VW-1:0] M0VLast    = VW'(M0_V_TOTAL - 1);
  localparam logic [VW-1:0] M0VAct     = VW'(M0_V_ACTIVE);
  localparam logic [VW-1:0] M0VsFirst  = VW'(M0_VS_START);
  localparam logic [VW-1:0] M0VsLast   = VW'(M0_VS_START + M0_VS_LEN - 1);
  localparam logic [HW-1:0] M1HLast    = HW'(M1_H_TOTAL - 1);
  localparam logic [HW-1:0] M1HAct     = HW'(M1_H_ACTIVE);
  localparam logic [HW-1:0] M1HsFirst  = HW'(M1_HS_START);
  localparam logic [HW-1:0] M1HsLast   = HW'(M1_HS_START + M1_HS_LEN - 1);
  localparam logic [VW-1:0] M1VLast    = VW'(M1_V_TOTAL - 1);
  localparam logic [VW-1:0] M1VAct     = VW'(M1_V_ACTIVE);
  localparam logic [VW-1:0] M1VsFirst  = VW'(M1_VS_START);
  localparam logic [VW-1:0] M1VsLast   = VW'(M1_VS_START + M1_VS_LEN - 1);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblnk_q, hblnk_d;
  logic          vblnk_q, vblnk_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          mode_act_q, mode_act_d;

  // Wrap points follow the mode in force; decode limits follow the mode of the next position.
  logic [HW-1:0] h_last, h_act, hs_first, hs_last;
  logic [VW-1:0] v_last, v_act, vs_first, vs_last;
  logic          h_wrap, v_wrap;

  always_comb begin
    h_last        = mode_act_q ? M1HLast : M0HLast;
    v_last        = mode_act_q ? M1VLast : M0VLast;
    h_wrap        = (hcount_q == h_last);
    v_wrap        = (vcount_q == v_last);

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_cnt_d   = frame_cnt_q;
    mode_act_d    = mode_act_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (tif.ce) begin
      line_start_d = h_wrap;
      if (h_wrap) begin
        hcount_d = '0;
        if (v_wrap) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 1'b1;
          mode_act_d    = tif.mode_sel;
        end else begin
          vcount_d = vcount_q + 1'b1;
        end
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end

    h_act    = mode_act_d ? M1HAct    : M0HAct;
    hs_first = mode_act_d ? M1HsFirst : M0HsFirst;
    hs_last  = mode_act_d ? M1HsLast  : M0HsLast;
    v_act    = mode_act_d ? M1VAct    : M0VAct;
    vs_first = mode_act_d ? M1VsFirst : M0VsFirst;
    vs_last  = mode_act_d ? M1VsLast  : M0VsLast;

    // With ce low the counts hold, so re-decoding them reproduces the held outputs.
    hblnk_d = (hcount_d >= h_act);
    vblnk_d = (vcount_d >= v_act);
    de_d    = ~hblnk_d & ~vblnk_d;
    hsync_d = ((hcount_d >= hs_first) && (hcount_d <= hs_last)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((vcount_d >= vs_first) && (vcount_d <= vs_last)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      mode_act_q    <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_act_q    <= mode_act_d;
    end
  end

  assign tif.hcount      = hcount_q;
  assign tif.vcount      = vcount_q;
  assign tif.hsync       = hsync_q;
  assign tif.vsync       = vsync_q;
  assign tif.hblnk       = hblnk_q;
  assign tif.vblnk       = vblnk_q;
  assign tif.de          = de_q;
  assign tif.line_start  = line_start_q;
  assign tif.frame_start = frame_start_q;
  assign tif.frame_cnt   = frame_cnt_q;
  assign tif.mode_act    = mode_act_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: scaled-down rasters, one active-high/FW=16 and one active-low/FW=2.
module tb_vga_timing_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_timing_param_if #(.HW(5), .VW(4), .FW(16)) vif ();
  vga_timing_param_if #(.HW(5), .VW(4), .FW(2))  vif2 ();

  assign vif2.ce       = vif.ce;
  assign vif2.mode_sel = vif.mode_sel;

  vga_timing_param #(
    .M0_H_TOTAL(20), .M0_H_ACTIVE(12), .M0_HS_START(14), .M0_HS_LEN(3),
    .M0_V_TOTAL(10), .M0_V_ACTIVE(6),  .M0_VS_START(7),  .M0_VS_LEN(2),
    .M1_H_TOTAL(16), .M1_H_ACTIVE(10), .M1_HS_START(11), .M1_HS_LEN(2),
    .M1_V_TOTAL(8),  .M1_V_ACTIVE(5),  .M1_VS_START(6),  .M1_VS_LEN(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HW(5), .VW(4), .FW(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tif (vif)
  );

  vga_timing_param #(
    .M0_H_TOTAL(20), .M0_H_ACTIVE(12), .M0_HS_START(14), .M0_HS_LEN(3),
    .M0_V_TOTAL(10), .M0_V_ACTIVE(6),  .M0_VS_START(7),  .M0_VS_LEN(2),
    .M1_H_TOTAL(16), .M1_H_ACTIVE(10), .M1_HS_START(11), .M1_HS_LEN(2),
    .M1_V_TOTAL(8),  .M1_V_ACTIVE(5),  .M1_VS_START(6),  .M1_VS_LEN(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HW(5), .VW(4), .FW(2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .tif (vif2)
  );

  int checks = 0;
  int errors = 0;
  int eh, ev, efc;
  bit emode, msel, ls, fs;
  logic [6:0] e, got;

  // Expected {hblnk, vblnk, de, hsync, vsync, line_start, frame_start} for active-high syncs.
  function automatic logic [6:0] exp_flags(int h, int v, bit m, bit l, bit f);
    int ha, hss, hsl, va, vss, vsl;
    logic hb, vb, hs, vs;
    if (m) begin
      ha = 10; hss = 11; hsl = 2; va = 5; vss = 6; vsl = 1;
    end else begin
      ha = 12; hss = 14; hsl = 3; va = 6; vss = 7; vsl = 2;
    end
    hb = (h >= ha);
    vb = (v >= va);
    hs = (h >= hss) && (h <= hss + hsl - 1);
    vs = (v >= vss) && (v <= vss + vsl - 1);
    return {hb, vb, ~hb & ~vb, hs, vs, l, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference raster position after one advancing edge.
  task automatic model_adv();
    int ht, vt;
    ht = emode ? 16 : 20;
    vt = emode ? 8 : 10;
    ls = 1'b0;
    fs = 1'b0;
    if (eh == ht - 1) begin
      eh = 0;
      ls = 1'b1;
      if (ev == vt - 1) begin
        ev = 0;
        fs = 1'b1;
        efc++;
        emode = msel;
      end else begin
        ev++;
      end
    end else begin
      eh++;
    end
  endtask

  function automatic logic [6:0] flags1();
    return {vif.hblnk, vif.vblnk, vif.de, vif.hsync, vif.vsync, vif.line_start, vif.frame_start};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    vif.ce = 1'b1;
    msel = 1'b0;
    vif.mode_sel = 1'b0;
    repeat (3) step();
    eh = 0; ev = 0; efc = 0; emode = 1'b0; ls = 1'b0; fs = 1'b0;
    checks++;
    if ({vif.hcount, vif.vcount} !== 9'd0) begin
      errors++;
      $display("FAIL reset_counts: got h=%0d v=%0d want 0 0", vif.hcount, vif.vcount);
    end
    got = flags1();
    checks++;
    if (got !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0010000", got);
    end
    checks++;
    if (vif.frame_cnt !== 16'd0 || vif.mode_act !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt_mode: got cnt=%0d mode=%0d want 0 0", vif.frame_cnt, vif.mode_act);
    end
    checks++;
    if ({vif2.hsync, vif2.vsync} !== 2'b11) begin
      errors++;
      $display("FAIL reset_lowpol_sync: got %b want 11", {vif2.hsync, vif2.vsync});
    end
    rst = 1'b0;
  endtask

  task automatic test_mode0_frames();
    step();
    model_adv();
    checks++;
    if (vif.hcount !== 5'd1 || vif.vcount !== 4'd0) begin
      errors++;
      $display("FAIL first_adv: got h=%0d v=%0d want 1 0", vif.hcount, vif.vcount);
    end
    for (int i = 1; i < 400; i++) begin
      step();
      model_adv();
      e = exp_flags(eh, ev, emode, ls, fs);
      got = flags1();
      checks++;
      if ({vif.hcount, vif.vcount} !== {eh[4:0], ev[3:0]}) begin
        errors++;
        $display("FAIL m0_pos: got h=%0d v=%0d want h=%0d v=%0d", vif.hcount, vif.vcount, eh, ev);
      end
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL m0_flags at h=%0d v=%0d: got %b want %b", eh, ev, got, e);
      end
      checks++;
      if ({vif2.hsync, vif2.vsync} !== ~e[3:2]) begin
        errors++;
        $display("FAIL m0_lowpol at h=%0d v=%0d: got %b want %b", eh, ev,
                 {vif2.hsync, vif2.vsync}, ~e[3:2]);
      end
      checks++;
      if (vif.frame_cnt !== efc[15:0] || vif2.frame_cnt !== efc[1:0]) begin
        errors++;
        $display("FAIL m0_frame_cnt: got %0d/%0d want %0d", vif.frame_cnt, vif2.frame_cnt, efc);
      end
    end
    checks++;
    if (vif.frame_cnt !== 16'd2 || vif.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL two_frames: got cnt=%0d fs=%0d want 2 1", vif.frame_cnt, vif.frame_start);
    end
  endtask

  task automatic test_fw_wrap();
    int seq [5];
    seq = '{1, 2, 3, 0, 1};
    for (int f = 3; f <= 5; f++) begin
      repeat (200) begin
        step();
        model_adv();
      end
      checks++;
      if (vif2.frame_start !== 1'b1 || vif2.frame_cnt !== seq[f-1][1:0]) begin
        errors++;
        $display("FAIL fw2_seq frame %0d: got fs=%0d cnt=%0d want 1 %0d", f, vif2.frame_start,
                 vif2.frame_cnt, seq[f-1]);
      end
    end
  endtask

  task automatic test_ce_toggle();
    int p0, p1;
    bit cev;
    p0 = -1;
    p1 = -1;
    for (int c = 1; c <= 800; c++) begin
      cev = (c % 2 == 1);
      vif.ce = cev;
      step();
      if (cev) model_adv();
      else begin
        ls = 1'b0;
        fs = 1'b0;
      end
      e = exp_flags(eh, ev, emode, ls, fs);
      got = flags1();
      checks++;
      if ({vif.hcount, vif.vcount} !== {eh[4:0], ev[3:0]} || got !== e) begin
        errors++;
        $display("FAIL ce_toggle c=%0d: got h=%0d v=%0d f=%b want h=%0d v=%0d f=%b", c,
                 vif.hcount, vif.vcount, got, eh, ev, e);
      end
      checks++;
      if (vif.frame_cnt !== efc[15:0]) begin
        errors++;
        $display("FAIL ce_hold_cnt c=%0d: got %0d want %0d", c, vif.frame_cnt, efc);
      end
      if (vif.frame_start === 1'b1) begin
        if (p0 < 0) p0 = c;
        else if (p1 < 0) p1 = c;
      end
    end
    checks++;
    if (p0 != 399 || p1 - p0 != 400) begin
      errors++;
      $display("FAIL ce_frame_period: got first=%0d period=%0d want 399 400", p0, p1 - p0);
    end
    vif.ce = 1'b1;
  endtask

  task automatic test_mode_switch();
    for (int i = 1; i <= 328; i++) begin
      step();
      model_adv();
      e = exp_flags(eh, ev, emode, ls, fs);
      got = flags1();
      checks++;
      if ({vif.hcount, vif.vcount} !== {eh[4:0], ev[3:0]} || got !== e
          || vif.mode_act !== emode) begin
        errors++;
        $display("FAIL mode_sw i=%0d: got h=%0d v=%0d f=%b m=%0d want h=%0d v=%0d f=%b m=%0d",
                 i, vif.hcount, vif.vcount, got, vif.mode_act, eh, ev, e, emode);
      end
      if (i == 60) begin
        checks++;
        if (vif.vcount !== 4'd3 || vif.mode_act !== 1'b0) begin
          errors++;
          $display("FAIL mode_pre: got v=%0d m=%0d want 3 0", vif.vcount, vif.mode_act);
        end
        msel = 1'b1;
        vif.mode_sel = 1'b1;
      end
      if (i == 200 || i == 328) begin
        checks++;
        if (vif.mode_act !== 1'b1 || vif.frame_start !== 1'b1) begin
          errors++;
          $display("FAIL mode_wrap i=%0d: got m=%0d fs=%0d want 1 1", i, vif.mode_act,
                   vif.frame_start);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    msel = 1'b0;
    vif.mode_sel = 1'b0;
    repeat (69) begin
      step();
      model_adv();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    eh = 0; ev = 0; efc = 0; emode = 1'b0; ls = 1'b0; fs = 1'b0;
    got = flags1();
    checks++;
    if ({vif.hcount, vif.vcount} !== 9'd0 || got !== 7'b0010000 || vif.frame_cnt !== 16'd0
        || vif.mode_act !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got h=%0d v=%0d f=%b cnt=%0d m=%0d want 0 0 0010000 0 0",
               vif.hcount, vif.vcount, got, vif.frame_cnt, vif.mode_act);
    end
    step();
    checks++;
    if (vif.hcount !== 5'd1 || vif.vcount !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_adv: got h=%0d v=%0d want 1 0", vif.hcount, vif.vcount);
    end
    repeat (19) step();
    checks++;
    if (vif.hcount !== 5'd0 || vif.vcount !== 4'd1 || vif.line_start !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_line: got h=%0d v=%0d ls=%0d want 0 1 1", vif.hcount,
               vif.vcount, vif.line_start);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_frames();
    test_fw_wrap();
    test_ce_toggle();
    test_mode_switch();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_param.md
VGA_TIMING_PARAM -- requirements
Module: vga_timing_param

Interface
REQ-001 SHALL have parameters: name, default, meaning.
- M0_H_TOTAL, 1344, mode-0 pixels per line
- M0_H_ACTIVE, 1024, mode-0 visible pixels
- M0_HS_START, 1048, mode-0 first hsync pixel
- M0_HS_LEN, 136, mode-0 hsync width
- M0_V_TOTAL, 806; M0_V_ACTIVE, 768; M0_VS_START, 771; M0_VS_LEN, 6 (mode-0 lines)
- M1_H_TOTAL, 1056; M1_H_ACTIVE, 800; M1_HS_START, 840; M1_HS_LEN, 128 (mode-1 pixels)
- M1_V_TOTAL, 628; M1_V_ACTIVE, 600; M1_VS_START, 601; M1_VS_LEN, 4 (mode-1 lines)
- HSYNC_POL, 1, active level of hsync
- VSYNC_POL, 1, active level of vsync
- HW, 11, hcount width
- VW, 10, vcount width
- FW, 16, frame_cnt width
REQ-002 SHALL have ports: name, direction, width, meaning.
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel enable; timing advances only on clk edges with ce=1
- mode_sel  in  1  requested timing set (0/1), sampled at frame wrap
- hcount  out  HW  current pixel in line
- vcount  out  VW  current line in frame
- hsync, vsync  out  1  sync outputs at configured polarity
- hblnk, vblnk  out  1  horizontal/vertical blanking
- de  out  1  data enable = active video
- line_start  out  1  one-cycle pulse, first pixel of each line
- frame_start  out  1  one-cycle pulse, first pixel of each frame
- frame_cnt  out  FW  completed-frame counter
- mode_act  out  1  timing set currently in use

Function
REQ-003 All outputs SHALL be registered; every output SHALL describe the (hcount, vcount) it is presented with in the same cycle (zero latency between counts and sync/blank/de).
REQ-004 On an advancing edge (ce=1): hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment; at (H_TOTAL-1, V_TOTAL-1) both SHALL wrap to 0.
REQ-005 With ce=0: hcount, vcount, sync, blank, de, frame_cnt, mode_act SHALL hold; line_start and frame_start SHALL be 0.
REQ-006 hblnk SHALL be 1 iff hcount >= H_ACTIVE; vblnk SHALL be 1 iff vcount >= V_ACTIVE; de SHALL equal ~hblnk & ~vblnk.
REQ-007 hsync SHALL equal HSYNC_POL iff HS_START <= hcount <= HS_START+HS_LEN-1, else ~HSYNC_POL.
REQ-008 vsync SHALL equal VSYNC_POL for whole lines VS_START..VS_START+VS_LEN-1 (every hcount of those lines), else ~VSYNC_POL.
REQ-009 line_start SHALL be 1 for exactly one clk cycle after an advancing edge that sets hcount to 0; frame_start likewise when both counts become 0; frame_start cycles SHALL also assert line_start.
REQ-010 frame_cnt SHALL increment by 1 on each frame wrap, modulo 2^FW.
REQ-011 mode_act SHALL load mode_sel only on the frame-wrap advancing edge; the new timing set SHALL apply from that (0,0) onward; mode_sel changes mid-frame SHALL have no effect until the wrap.
REQ-012 Timing SHALL use M0_* when mode_act=0 and M1_* when mode_act=1; all comparisons unsigned at HW/VW width.
REQ-013 Legal parameters: H_ACTIVE < HS_START, HS_START+HS_LEN <= H_TOTAL <= 2^HW, same for V with VW; other combinations unsupported.

Reset
REQ-014 rst=1 SHALL override ce and set: hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, frame_cnt=0, mode_act=0.
REQ-015 Reset asserted mid-frame SHALL take effect on the next clk edge; first advancing edge after release SHALL yield hcount=1.

Verification
REQ-016 Defaults, ce=1, mode_sel=0, 2 frames -> hblnk rises at hcount=1024, hsync active hcount 1048..1183, vsync active vcount 771..776, frame_start every 1344*806 cycles, frame_cnt=2.
REQ-017 ce toggling 1/0 each cycle -> counts advance every other cycle, line_start width exactly 1 cycle, frame period 2*1344*806 cycles.
REQ-018 mode_sel 0->1 at vcount=300 -> mode_act stays 0 to frame end, then 1; next line period 1056, frame 1056*628, hblnk rises at 800.
REQ-019 HSYNC_POL=0, VSYNC_POL=0 -> syncs idle 1, low over same windows as REQ-016; reset value 1.
REQ-020 rst pulse at (500,400) -> next cycle all REQ-014 values; frame_cnt=0; timing resumes from (0,0).
REQ-021 FW=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.
